// File: rtl/ibex_lsu_resp_unit.sv
// Data-side load/store unit: issues req/gnt/rvalid bus transactions, splits
// misaligned accesses into two words and aligns/extends the load result.
module ibex_lsu_resp_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  output logic        lsu_req_ready_o,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_data_valid_o,
  output logic        lsu_err_o,
  output logic        busy_o
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            part_q, part_d;
  logic            we_q, sign_q;
  logic [1:0]      type_q;
  logic [DW-1:0]   addr_q, wdata_q, lo_q;
  logic            valid_q, err_q, rf_we_q;
  logic [DW-1:0]   rf_wdata_q;
  logic            orphan_q;

  logic            accept_c, final_c, split_c;
  logic [3:0]      mask_c;
  logic [7:0]      be_wide_c;
  logic [4:0]      sh_c;
  logic [2*DW-1:0] rot_c, shift_c;
  logic [DW-1:0]   lo_sel_c, v_c, ext_c;

  // Access geometry derived from the latched request
  always_comb begin
    mask_c = 4'b1111;
    case (type_q)
      2'b01:   mask_c = 4'b0011;
      2'b10:   mask_c = 4'b0001;
      default: mask_c = 4'b1111;
    endcase
  end

  assign split_c   = ((type_q == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                     ((type_q != 2'b01) && (type_q != 2'b10) && (addr_q[1:0] != 2'b00));
  assign sh_c      = {addr_q[1:0], 3'b000};
  assign be_wide_c = {4'b0000, mask_c} << addr_q[1:0];
  assign rot_c     = {wdata_q, wdata_q} << sh_c;

  assign lsu_req_ready_o = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign data_req_o      = (state_q == REQ);
  assign data_we_o       = we_q;
  assign data_be_o       = part_q ? be_wide_c[7:4] : be_wide_c[3:0];
  assign data_wdata_o    = rot_c[2*DW-1:DW];
  assign data_addr_o     = {addr_q[31:2], 2'b00} + {29'd0, part_q, 2'b00};

  // Load alignment: the second word (or the only word) supplies the high half
  assign lo_sel_c = part_q ? lo_q : data_rdata_i;
  assign shift_c  = {data_rdata_i, lo_sel_c} >> sh_c;
  assign v_c      = shift_c[DW-1:0];

  always_comb begin
    ext_c = v_c;
    case (type_q)
      2'b01:   ext_c = {{16{sign_q & v_c[15]}}, v_c[15:0]};
      2'b10:   ext_c = {{24{sign_q & v_c[7]}}, v_c[7:0]};
      default: ext_c = v_c;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    accept_c = 1'b0;
    final_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          accept_c = 1'b1;
          state_d  = REQ;
          part_d   = 1'b0;
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (data_rvalid_i) begin
          if (data_err_i || !split_c || part_q) begin
            final_c = 1'b1;
            state_d = IDLE;
          end else begin
            part_d  = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      part_q     <= 1'b0;
      we_q       <= 1'b0;
      type_q     <= 2'b00;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      if (accept_c) begin
        we_q    <= lsu_we_i;
        type_q  <= lsu_type_i;
        sign_q  <= lsu_sign_ext_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
      end
      if ((state_q == RESP) && data_rvalid_i && !part_q) lo_q <= data_rdata_i;
      valid_q    <= final_c;
      err_q      <= final_c & data_err_i;
      rf_we_q    <= final_c & !we_q & !data_err_i;
      rf_wdata_q <= (final_c && !we_q && !data_err_i) ? ext_c : '0;
    end
  end

  assign lsu_data_valid_o = valid_q;
  assign lsu_err_o        = err_q;
  assign rf_we_lsu_o      = rf_we_q;
  assign rf_wdata_lsu_o   = rf_wdata_q;

  // Remembers a bus transaction abandoned by reset so its late rvalid is legal
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      orphan_q <= orphan_q | (state_q == RESP) | ((state_q == REQ) & data_gnt_i);
    end else if (data_rvalid_i && (state_q != RESP)) begin
      orphan_q <= 1'b0;
    end
  end

  a_we_implies_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    rf_we_lsu_o |-> lsu_data_valid_o);

  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (data_req_o && !data_gnt_i) |=> (data_req_o && $stable(data_addr_o) &&
      $stable(data_be_o) && $stable(data_we_o) && $stable(data_wdata_o)));

  a_be_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    data_req_o |-> (data_be_o != 4'b0000));

  a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    data_rvalid_i |-> ((state_q == RESP) || orphan_q));

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Randomized bench for ibex_lsu_resp_unit against a byte-addressed memory model.
module tb_ibex_lsu_resp_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_req_ready_o, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o, lsu_data_valid_o, lsu_err_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [29:0]];

  always #5 clk = ~clk;

  ibex_lsu_resp_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .rf_wdata_lsu_o(rf_wdata_lsu_o), .rf_we_lsu_o(rf_we_lsu_o),
    .lsu_data_valid_o(lsu_data_valid_o), .lsu_err_o(lsu_err_o), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mem_touch(input logic [29:0] idx);
    if (!mem.exists(idx)) mem[idx] = $urandom;
  endtask

  // One complete LSU transaction; errmode 0=random errors, 1=none, 2=error on first word
  task automatic run_txn(input logic we, input logic [1:0] ty, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata, input int errmode);
    int          size, np, g, r, lane, p;
    logic [31:0] b, wa0, wa, val, tmp, lmask;
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic        e, errored;

    size = (ty == 2'b01) ? 2 : (ty == 2'b10) ? 1 : 4;
    wa0  = {addr[31:2], 2'b00};
    np   = 1;
    ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
    for (int i = 0; i < size; i++) begin
      b    = addr + 32'(i);
      p    = ({b[31:2], 2'b00} == wa0) ? 0 : 1;
      if (p == 1) np = 2;
      lane = int'(b[1:0]);
      ebe[p][lane] = 1'b1;
      ewd[p][8*lane +: 8] = wdata[8*i +: 8];
    end

    check_eq("ready", 32'(lsu_req_ready_o), 32'd1);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty; lsu_sign_ext_i = sx;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(negedge clk);
    lsu_req_i = 1'b0; lsu_addr_i = $urandom; lsu_wdata_i = $urandom;

    errored = 1'b0;
    for (int pp = 0; pp < np; pp++) begin
      wa = wa0 + 32'(4 * pp);
      g  = $urandom_range(0, 2);
      for (int c = 0; c <= g; c++) begin
        check_eq("bus_req", 32'(data_req_o), 32'd1);
        check_eq("bus_addr", data_addr_o, wa);
        check_eq("bus_be", 32'(data_be_o), 32'(ebe[pp]));
        check_eq("bus_we", 32'(data_we_o), 32'(we));
        if (we) begin
          lmask = {{8{ebe[pp][3]}}, {8{ebe[pp][2]}}, {8{ebe[pp][1]}}, {8{ebe[pp][0]}}};
          check_eq("bus_wdata", data_wdata_o & lmask, ewd[pp]);
        end
        data_gnt_i = (c == g);
        @(negedge clk);
      end
      data_gnt_i = 1'b0;
      r = $urandom_range(0, 2);
      for (int c = 0; c < r; c++) begin
        check_eq("req_low_in_resp", 32'(data_req_o), 32'd0);
        @(negedge clk);
      end
      e = (errmode == 2) ? (pp == 0) : (errmode == 1) ? 1'b0 : ($urandom_range(0, 7) == 0);
      mem_touch(wa[31:2]);
      check_eq("no_early_valid", 32'(lsu_data_valid_o), 32'd0);
      data_rvalid_i = 1'b1;
      data_err_i    = e;
      data_rdata_i  = we ? $urandom : mem[wa[31:2]];
      if (we && !e) begin
        for (int i = 0; i < size; i++) begin
          b = addr + 32'(i);
          if ({b[31:2], 2'b00} == wa) begin
            tmp = mem[b[31:2]];
            tmp[8*int'(b[1:0]) +: 8] = wdata[8*i +: 8];
            mem[b[31:2]] = tmp;
          end
        end
      end
      @(negedge clk);
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
      if (e) begin
        errored = 1'b1;
        break;
      end
    end

    val = '0;
    if (!we && !errored) begin
      for (int i = 0; i < size; i++) begin
        b   = addr + 32'(i);
        tmp = mem[b[31:2]];
        val[8*i +: 8] = tmp[8*int'(b[1:0]) +: 8];
      end
      if (size == 2) val = sx ? {{16{val[15]}}, val[15:0]} : {16'd0, val[15:0]};
      if (size == 1) val = sx ? {{24{val[7]}}, val[7:0]} : {24'd0, val[7:0]};
    end

    check_eq("valid", 32'(lsu_data_valid_o), 32'd1);
    check_eq("err", 32'(lsu_err_o), 32'(errored));
    check_eq("rf_we", 32'(rf_we_lsu_o), 32'(!we && !errored));
    check_eq("rf_wdata", rf_wdata_lsu_o, val);
    check_eq("idle_after", 32'(lsu_req_ready_o), 32'd1);
    check_eq("no_req_after", 32'(data_req_o), 32'd0);
    @(negedge clk);
    check_eq("valid_pulse", 32'(lsu_data_valid_o), 32'd0);
    check_eq("rf_we_pulse", 32'(rf_we_lsu_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check_eq("rst_valid", 32'(lsu_data_valid_o), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we_lsu_o), 32'd0);
    check_eq("rst_rf_wdata", rf_wdata_lsu_o, 32'd0);
    check_eq("rst_err", 32'(lsu_err_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_req", 32'(data_req_o), 32'd0);
    check_eq("rst_ready", 32'(lsu_req_ready_o), 32'd1);

    // Directed scenarios
    mem[30'h40] = 32'hDEADBEEF;
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 1);
    mem[30'h80] = 32'h80FFFFFF;
    run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0203, 32'h0, 1);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0203, 32'h0, 1);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h11223344, 1);
    mem[30'h3FFF_FFFF] = 32'h7F12_3456;
    mem[30'h0]         = 32'hABCD_EF80;
    run_txn(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 1);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0, 2);

    // Reset while waiting for rvalid, then a late rvalid
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_addr_i = 32'h400;
    @(negedge clk);
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    check_eq("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("late_valid", 32'(lsu_data_valid_o), 32'd0);
      check_eq("late_rf_we", 32'(rf_we_lsu_o), 32'd0);
      check_eq("late_rf_wdata", rf_wdata_lsu_o, 32'd0);
      check_eq("late_busy", 32'(busy_o), 32'd0);
      check_eq("late_ready", 32'(lsu_req_ready_o), 32'd1);
      @(negedge clk);
    end

    // Random traffic, biased toward a small address window and the wrap point
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = $urandom;
      case ($urandom_range(0, 2))
        0: a = {24'd0, a[7:0]};
        1: a = 32'hFFFF_FFF0 | {28'd0, a[3:0]};
        default: ;
      endcase
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_lsu_resp_unit.md
Name: ibex_lsu_resp_unit

Overview:
- Data-side load/store unit between the ID/EX stage and the writeback stage.
- Accepts one load/store request at a time from ID/EX and drives the data bus using the req/gnt/rvalid protocol.
- Splits misaligned accesses into two word transactions, then aligns and sign/zero-extends load data.
- Produces the LSU register-file write port and the LSU data-valid strobe that the writeback stage consumes.

Parameters:
- None. Data and address widths are fixed at 32 bits.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
lsu_req_i  in  1  request valid from ID/EX
lsu_req_ready_o  out  1  unit can accept a request this cycle
lsu_we_i  in  1  1=store, 0=load
lsu_type_i  in  2  00=word, 01=half, 10=byte (11 reserved, treated as word)
lsu_sign_ext_i  in  1  sign-extend load result
lsu_addr_i  in  32  byte address
lsu_wdata_i  in  32  store data, LSB-aligned
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_rvalid_i  in  1  bus response valid
data_rdata_i  in  32  bus read data
data_err_i  in  1  bus error, qualified by data_rvalid_i
rf_wdata_lsu_o  out  32  load result
rf_we_lsu_o  out  1  load result write enable
lsu_data_valid_o  out  1  response complete (load or store)
lsu_err_o  out  1  response completed with error
busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- FSM states: IDLE, REQ, RESP. Part bit p: 0 = first word, 1 = second word.
- Reset (sync, rst_i=1):
  - state=IDLE, p=0.
  - data_req_o, rf_we_lsu_o, lsu_data_valid_o, lsu_err_o, busy_o = 0; rf_wdata_lsu_o=0.
  - Any rvalid arriving after reset for a pre-reset transaction is ignored.
- lsu_req_ready_o = (state==IDLE). Acceptance = lsu_req_i & ready.
  - On acceptance, latch we/type/sign/addr/wdata; go to REQ with p=0.
- Misaligned (split = 1) when:
  - word with addr[1:0] != 0, or
  - half with addr[1:0] == 3.
  - Byte accesses never split.
- REQ:
  - data_req_o=1. Address/we/be/wdata held stable until grant.
  - data_addr_o = {addr[31:2],2'b00} + 4*p; wraps modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
  - Let m = 0xF (word), 0x3 (half), 0x1 (byte); o = addr[1:0].
  - data_be_o = ({4'b0,m} << o)[3:0] for p=0, and ({4'b0,m} << o)[7:4] for p=1.
  - data_wdata_o = wdata rotated left by 8*o (same value for both parts).
  - data_gnt_i=1 → RESP.
- RESP:
  - data_req_o=0.
  - On data_rvalid_i: if p=0, capture data_rdata_i into buffer lo.
  - If (data_err_i | !split | p==1) → IDLE. A new request may be accepted in that same IDLE cycle.
  - Otherwise p=1 → REQ.
  - An error on part 0 aborts part 1; no second bus request is issued.
- Response outputs are registered and pulse for exactly one cycle, the cycle after the final rvalid:
  - lsu_data_valid_o=1.
  - lsu_err_o=data_err_i.
  - rf_we_lsu_o = !we & !err.
  - rf_wdata_lsu_o = extracted load data (0 for stores/errors).
- Load extraction:
  - v = ({hi,lo} >> 8*o)[31:0], where hi = second rdata, or lo = rdata if not split.
  - Word → v.
  - Half → v[15:0], sign- or zero-extended per lsu_sign_ext_i.
  - Byte → v[7:0], sign- or zero-extended per lsu_sign_ext_i.
- Bus protocol: rvalid arrives no earlier than the cycle after gnt. rvalid outside RESP is a protocol violation, covered by an assertion and ignored by the FSM.
- Assertions:
  - rf_we_lsu_o implies lsu_data_valid_o.
  - data_req_o held until data_gnt_i.
  - data_be_o != 0 whenever data_req_o.

Test Plan:
1. Aligned load word, addr 0x100; gnt on first REQ cycle, rdata 0xDEADBEEF one cycle later → data_addr_o=0x100, be=0xF; next cycle rf_we_lsu_o=1, rf_wdata_lsu_o=0xDEADBEEF, lsu_data_valid_o pulse of 1 cycle.
2. Signed byte load, addr 0x203, rdata 0x80FFFFFF → be=0x8, result 0xFFFFFF80. Same access unsigned → result 0x00000080.
3. Misaligned word store, addr 0x102, wdata 0x11223344:
   - part 0: addr 0x100, be=0xC, wdata 0x33441122.
   - part 1: addr 0x104, be=0x3.
   - One lsu_data_valid_o pulse, rf_we_lsu_o=0.
4. Misaligned signed half load, addr 0xFFFFFFFF; rdata 0x7Fxxxxxx then 0xxxxxxx80 → second address 0x00000000; result 0xFFFF807F.
5. Misaligned word load with data_err_i on part 0 → no second data_req_o; lsu_err_o=1, lsu_data_valid_o=1, rf_we_lsu_o=0.
6. rst_i asserted while in RESP, followed by a late rvalid → outputs stay 0, state=IDLE, lsu_req_ready_o=1, no response pulse.
